pg_switch_sequencer: RTL
========================

Name: pg_switch_sequencer

Overview:
- Single-clock controller that sequences a power-gated domain built from transistor-level cells.
- The domain's supply is switched by N_STAGES segmented PMOS header banks.
- Power-up is staggered, one bank per STAGE_DLY cycles, to limit rush current. This is followed by a settle wait, domain-reset release, isolation release and acknowledge.
- Power-down reverses the order: isolate, reset, then all headers off.
- Sits between the chip power manager (pwr_req/pwr_ack) and the domain's header gates, isolation cells and domain reset.

Parameters:
- N_STAGES, 4: number of header-switch banks; must be >= 1.
- STAGE_DLY, 8: clock cycles between successive bank enables; must be >= 1.
- SETTLE_DLY, 16: cycles from the last bank enable to domain-reset release; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- pwr_req  input  1  level request: 1 = domain on, 0 = domain off.
- pwr_ack  output  1  1 only while the domain is fully on and de-isolated.
- sw_en  output  N_STAGES  header bank enables; 1 = bank conducting. Drives the header gate through an external inverter.
- iso_en  output  1  1 = domain outputs clamped.
- dom_rst  output  1  1 = domain held in reset.
- busy  output  1  1 while in any transitional state.
- state  output  3  current FSM state encoding, for debug and status.

Behaviour:
- Reset (rst=1 sampled at an edge) gives, from the next cycle:
  - state=OFF, sw_en=0, iso_en=1, dom_rst=1, pwr_ack=0, busy=0, counters=0.
  - Reset mid-sequence aborts immediately to these values; all banks drop in the same cycle.
- States: OFF, RAMP, SETTLE, DERST, ON, ISO, RSTA. All outputs are registered.
- OFF:
  - Outputs hold their reset values.
  - pwr_req=1 sampled at edge T gives RAMP at T+1, sw_en[0]=1 at T+1, busy=1 at T+1.
- RAMP:
  - sw_en[k] rises at T+1+k*STAGE_DLY. Banks are thermometer-coded and never drop during RAMP.
  - When sw_en[N_STAGES-1] rises, the FSM enters SETTLE.
- SETTLE: dom_rst falls at T+1+(N_STAGES-1)*STAGE_DLY+SETTLE_DLY; the FSM enters DERST in that cycle.
- DERST: exactly one cycle. On the next cycle iso_en=0, pwr_ack=1, busy=0, state=ON.
- ON: pwr_req=0 sampled at edge U gives the following sequence.
  - U+1: ISO, iso_en=1, pwr_ack=0, busy=1.
  - U+2: RSTA, dom_rst=1.
  - U+3: OFF, sw_en=0 (all banks at once), busy=0.
- No abort on request change: a pwr_req toggle during RAMP, SETTLE, DERST, ISO or RSTA is ignored until the sequence reaches ON or OFF. The level is then re-evaluated, so pwr_req=0 held at the end of power-up starts power-down on the first ON cycle edge.
- Invariants, which the bench checks every cycle:
  - pwr_ack=1 implies sw_en all ones, iso_en=0 and dom_rst=0.
  - iso_en=0 implies dom_rst=0.
  - dom_rst=0 implies sw_en all ones.
  - sw_en is always thermometer-coded from bit 0.
- Counter: one shared down-counter, width $clog2(max(STAGE_DLY,SETTLE_DLY)+1).
  - It is reloaded on each stage or phase entry and never wraps.
  - Stage index width is $clog2(N_STAGES+1).
- N_STAGES=1: RAMP lasts exactly one cycle before SETTLE.
- STAGE_DLY=1: one new bank every cycle.

Decomposition:
- Package pg_pkg holds:
  - the state enum typedef (3-bit encoding, OFF=0);
  - a max_dly helper function;
  - the counter-width constant function.
- Sub-module pg_delay_cnt: a loadable down-counter with a load value, a load strobe and a zero flag, instantiated once.
- FSM and output registers live in pg_switch_sequencer.

Test Plan:
1. Defaults; release rst, pwr_req=1 at edge 0:
   - sw_en goes 0001 at cycle 1, 0011 at 9, 0111 at 17, 1111 at 25;
   - dom_rst=0 at 41;
   - iso_en=0 and pwr_ack=1 at 42; busy=0 at 42.
2. From ON, pwr_req=0 at edge U: iso_en=1 and pwr_ack=0 at U+1; dom_rst=1 at U+2; sw_en=0000 and state=OFF at U+3.
3. pwr_req pulses 1 for one cycle only: the full power-up completes (pwr_ack=1 at cycle 42), then power-down starts at the first ON edge; pwr_ack=0 at cycle 43.
4. rst asserted at cycle 20 mid-RAMP (sw_en=0111): next cycle all outputs are at reset values. With pwr_req still 1, the sequence restarts from sw_en=0001.
5. N_STAGES=1, STAGE_DLY=1, SETTLE_DLY=1 build: pwr_req=1 at edge 0 gives sw_en=1 at 1, dom_rst=0 at 2, pwr_ack=1 at 3. Invariant assertions pass throughout randomized pwr_req toggling for 10k cycles.

Source files
------------

// File: rtl/pg_pkg.sv
// Shared types and sizing helpers for the power-gate switch sequencer.
package pg_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DERST  = 3'd3,
    ST_ON     = 3'd4,
    ST_ISO    = 3'd5,
    ST_RSTA   = 3'd6
  } pg_state_e;

  function automatic int max_dly(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the largest delay; loads are delay-1 so it never wraps.
  function automatic int cnt_width(input int stage_dly, input int settle_dly);
    return $clog2(max_dly(stage_dly, settle_dly) + 1);
  endfunction

endpackage

// File: rtl/pg_delay_cnt.sv
// Loadable down-counter that parks at zero and flags it.
module pg_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pg_switch_sequencer.sv
// Staggered header-bank power-up / isolate-reset-off power-down sequencer.
module pg_switch_sequencer
  import pg_pkg::*;
#(
  parameter int N_STAGES   = 4,
  parameter int STAGE_DLY  = 8,
  parameter int SETTLE_DLY = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pwr_req_i,
  output logic                pwr_ack_o,
  output logic [N_STAGES-1:0] sw_en_o,
  output logic                iso_en_o,
  output logic                dom_rst_o,
  output logic                busy_o,
  output logic [2:0]          state_o
);

  localparam int CW = cnt_width(STAGE_DLY, SETTLE_DLY);
  localparam int SW = $clog2(N_STAGES + 1);
  localparam logic [CW-1:0] LD_STAGE  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_DLY - 1);
  localparam logic [SW-1:0] STG_ALL   = SW'(N_STAGES);

  pg_state_e             state_q, state_d;
  logic [N_STAGES-1:0]   sw_en_q, sw_en_d;
  logic [SW-1:0]         stg_q, stg_d;
  logic                  iso_q, iso_d, dr_q, dr_d, ack_q, ack_d, busy_q, busy_d;
  logic                  ld;
  logic [CW-1:0]         ld_val;
  logic                  cnt_zero;

  pg_delay_cnt #(.W(CW)) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    sw_en_d = sw_en_q;
    stg_d   = stg_q;
    ld      = 1'b0;
    ld_val  = LD_STAGE;
    case (state_q)
      ST_OFF: if (pwr_req_i) begin
        state_d = ST_RAMP;
        sw_en_d = N_STAGES'(1);
        stg_d   = SW'(1);
        ld      = 1'b1;
        ld_val  = (N_STAGES == 1) ? LD_SETTLE : LD_STAGE;
      end
      ST_RAMP: begin
        // A single-bank build is already fully on here; RAMP doubles as the first settle cycle.
        if (stg_q == STG_ALL) begin
          state_d = cnt_zero ? ST_DERST : ST_SETTLE;
        end else if (cnt_zero) begin
          sw_en_d = (sw_en_q << 1) | N_STAGES'(1);
          stg_d   = stg_q + SW'(1);
          ld      = 1'b1;
          if (stg_d == STG_ALL) begin
            state_d = ST_SETTLE;
            ld_val  = LD_SETTLE;
          end
        end
      end
      ST_SETTLE: if (cnt_zero) state_d = ST_DERST;
      ST_DERST:  state_d = ST_ON;
      ST_ON:     if (!pwr_req_i) state_d = ST_ISO;
      ST_ISO:    state_d = ST_RSTA;
      ST_RSTA: begin
        state_d = ST_OFF;
        sw_en_d = '0;
        stg_d   = '0;
      end
      default: begin
        state_d = ST_OFF;
        sw_en_d = '0;
        stg_d   = '0;
      end
    endcase

    iso_d  = (state_d != ST_ON);
    ack_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_ON) && (state_d != ST_OFF);
    dr_d   = (state_d == ST_OFF) || (state_d == ST_RAMP) ||
             (state_d == ST_SETTLE) || (state_d == ST_RSTA);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      sw_en_q <= '0;
      stg_q   <= '0;
      iso_q   <= 1'b1;
      dr_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_en_q <= sw_en_d;
      stg_q   <= stg_d;
      iso_q   <= iso_d;
      dr_q    <= dr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign pwr_ack_o = ack_q;
  assign sw_en_o   = sw_en_q;
  assign iso_en_o  = iso_q;
  assign dom_rst_o = dr_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;

endmodule
